// File: rtl/stream_qos_arbiter_rr_if.sv
// Stream bundle for the QoS arbiter: N slave-side input streams plus one master output port.
// The slave modport is the arbiter's view of the inputs; the master modport is its view of the output.
interface stream_qos_arbiter_rr_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH  = 4,
    parameter int STREAM_COUNT = 2,
    parameter int ID_WIDTH     = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1
);
    logic [T_DATA_WIDTH-1:0] s_data_i [STREAM_COUNT-1:0];
    logic [T_QOS_WIDTH-1:0]  s_qos_i  [STREAM_COUNT-1:0];
    logic [STREAM_COUNT-1:0] s_last_i;
    logic [STREAM_COUNT-1:0] s_valid_i;
    logic [STREAM_COUNT-1:0] s_ready_o;

    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic [T_QOS_WIDTH-1:0]  m_qos_o;
    logic [ID_WIDTH-1:0]     m_id_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave  (input s_data_i, s_qos_i, s_last_i, s_valid_i, output s_ready_o);
    modport master (output m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o, input m_ready_i);
endinterface

// File: rtl/stream_qos_arbiter_rr.sv
// Packet-level N:1 QoS arbiter with round-robin tie-break and aging; first beat out 2 cycles after IDLE.
// Backpressure: granted stream's s_ready_o drops only when both skid entries are full.
module stream_qos_arbiter_rr #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH  = 4,
    parameter int STREAM_COUNT = 2,
    parameter int AGE_LIMIT    = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    stream_qos_arbiter_rr_if.slave  s_if,
    stream_qos_arbiter_rr_if.master m_if
);
    localparam int ID_WIDTH = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1;
    localparam int AGE_W    = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam int PRIO_W   = T_QOS_WIDTH + 1;

    typedef enum logic {IDLE, BUSY} state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0]     id;
        logic [T_QOS_WIDTH-1:0]  qos;
        logic [T_DATA_WIDTH-1:0] data;
        logic                    last;
    } beat_t;

    state_e                  state_q;
    logic [ID_WIDTH-1:0]     grant_q;
    logic [ID_WIDTH-1:0]     ptr_q;
    logic [T_QOS_WIDTH-1:0]  gqos_q;
    logic [AGE_W-1:0]        age_q [STREAM_COUNT];
    beat_t                   head_q;
    beat_t                   tail_q;
    logic [1:0]              cnt_q;

    logic [STREAM_COUNT-1:0] aged;
    logic [ID_WIDTH-1:0]     win_id;
    logic [ID_WIDTH-1:0]     cand;
    logic [PRIO_W-1:0]       win_prio;
    logic [PRIO_W-1:0]       cand_prio;
    logic                    win_found;
    logic                    any_valid;
    logic                    skid_free;
    logic                    push;
    logic                    pop;
    beat_t                   in_beat;

    always_comb begin
        for (int i = 0; i < STREAM_COUNT; i++) begin
            aged[i] = (AGE_LIMIT != 0) && (age_q[i] == AGE_W'(AGE_LIMIT));
        end
    end

    // Scan from the rr pointer; strict '>' keeps the earliest stream in rr order on ties.
    always_comb begin
        win_id    = '0;
        win_prio  = '0;
        win_found = 1'b0;
        cand      = '0;
        cand_prio = '0;
        for (int k = 0; k < STREAM_COUNT; k++) begin
            cand      = ID_WIDTH'((int'(ptr_q) + k) % STREAM_COUNT);
            cand_prio = aged[cand] ? {1'b1, {T_QOS_WIDTH{1'b0}}} : {1'b0, s_if.s_qos_i[cand]};
            if (s_if.s_valid_i[cand] && (!win_found || (cand_prio > win_prio))) begin
                win_found = 1'b1;
                win_id    = cand;
                win_prio  = cand_prio;
            end
        end
    end

    assign any_valid = |s_if.s_valid_i;
    assign skid_free = (cnt_q != 2'd2);
    assign push      = (state_q == BUSY) && skid_free && s_if.s_valid_i[grant_q];
    assign pop       = (cnt_q != 2'd0) && m_if.m_ready_i;
    assign in_beat   = {grant_q, gqos_q, s_if.s_data_i[grant_q], s_if.s_last_i[grant_q]};

    always_comb begin
        s_if.s_ready_o = '0;
        if ((state_q == BUSY) && skid_free) begin
            s_if.s_ready_o[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            gqos_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < STREAM_COUNT; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        state_q <= BUSY;
                        grant_q <= win_id;
                        gqos_q  <= s_if.s_qos_i[win_id];
                        ptr_q   <= (win_id == ID_WIDTH'(STREAM_COUNT - 1)) ? '0 : win_id + ID_WIDTH'(1);
                        for (int i = 0; i < STREAM_COUNT; i++) begin
                            if (ID_WIDTH'(i) == win_id) begin
                                age_q[i] <= '0;
                            end else if (s_if.s_valid_i[i] && (age_q[i] != AGE_W'(AGE_LIMIT))) begin
                                age_q[i] <= age_q[i] + AGE_W'(1);
                            end
                        end
                    end
                end
                BUSY: begin
                    if (push && s_if.s_last_i[grant_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // head_q is the output register; tail_q holds the second beat while the master stalls.
            if (push && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
                head_q <= in_beat;
            end else if (pop && (cnt_q == 2'd2)) begin
                head_q <= tail_q;
            end
            if (push && (cnt_q == 2'd1) && !pop) begin
                tail_q <= in_beat;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_if.m_data_o  = head_q.data;
    assign m_if.m_qos_o   = head_q.qos;
    assign m_if.m_id_o    = head_q.id;
    assign m_if.m_last_o  = head_q.last;
    assign m_if.m_valid_o = (cnt_q != 2'd0);
endmodule
